// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: req/addr_ok/data_ok bus master with alignment checks and load extension.
// Optional MEM_TIMEOUT_EN: aborts a transaction stuck in REQ/WAIT after TIMEOUT cycles and pulses bus_err.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validM,
  input  logic [5:0]        opM,
  input  logic [31:0]       aluoutM,
  input  logic [31:0]       writedataM,
  output logic [31:0]       readdataM,
  output logic              stall_mem,
  output logic              adel,
  output logic              ades,
  output logic [31:0]       badvaddr,
  output logic              bus_err,
  output logic              data_req,
  output logic              data_wr,
  output logic [3:0]        data_be,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic        is_load, is_store, misaligned, start, done_ok, timeout;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [5:0]  op_q;
  logic [31:0] vaddr_q;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_val;

  always_comb begin
    is_load    = validM && (opM inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU});
    is_store   = validM && (opM inside {OP_SB, OP_SH, OP_SW});
    misaligned = 1'b0;
    case (opM)
      OP_LH, OP_LHU, OP_SH: misaligned = aluoutM[0];
      OP_LW, OP_SW:         misaligned = |aluoutM[1:0];
      default:              misaligned = 1'b0;
    endcase
    start = (state == IDLE) && (is_load || is_store) && !misaligned;
  end

  // Store lanes: data is replicated so the selected byte enables pick the right copy.
  always_comb begin
    be_nxt    = 4'hF;
    wdata_nxt = 32'h0;
    case (opM)
      OP_SB: begin
        be_nxt    = 4'b0001 << aluoutM[1:0];
        wdata_nxt = {4{writedataM[7:0]}};
      end
      OP_SH: begin
        be_nxt    = aluoutM[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{writedataM[15:0]}};
      end
      OP_SW:   wdata_nxt = writedataM;
      default: be_nxt    = 4'hF;
    endcase
  end

  assign done_ok = ((state == REQ) && data_addr_ok && data_data_ok) ||
                   ((state == WAIT) && data_data_ok);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
  logic             bus_err_q;

  assign timeout = ((state == REQ) || (state == WAIT)) && (cnt == CNT_W'(TIMEOUT - 1));
  assign bus_err = bus_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (start) cnt <= '0;
      else if ((state == REQ) || (state == WAIT)) cnt <= cnt + 1'b1;
      bus_err_q <= timeout && !done_ok;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout        = 1'b0;
  assign bus_err        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    data_req  = 1'b0;
    stall_mem = 1'b0;
    adel      = 1'b0;
    ades      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = REQ;
          stall_mem = 1'b1;
        end else if (misaligned) begin
          adel = is_load;
          ades = is_store;
        end
      end
      REQ: begin
        data_req  = 1'b1;
        stall_mem = 1'b1;
        if (data_addr_ok && data_data_ok) state_nxt = DONE;
        else if (timeout)                 state_nxt = DONE;
        else if (data_addr_ok)            state_nxt = WAIT;
      end
      WAIT: begin
        stall_mem = 1'b1;
        if (data_data_ok || timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      data_req  = 1'b0;
      stall_mem = 1'b0;
      adel      = 1'b0;
      ades      = 1'b0;
    end
  end

  // Extraction uses the offset/opcode captured at issue, not the live M-stage inputs.
  always_comb begin
    rbyte = data_rdata[7:0];
    case (vaddr_q[1:0])
      2'd0: rbyte = data_rdata[7:0];
      2'd1: rbyte = data_rdata[15:8];
      2'd2: rbyte = data_rdata[23:16];
      2'd3: rbyte = data_rdata[31:24];
      default: rbyte = data_rdata[7:0];
    endcase
    rhalf    = vaddr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    load_val = data_rdata;
    case (op_q)
      OP_LB:   load_val = {{24{rbyte[7]}}, rbyte};
      OP_LBU:  load_val = {24'h0, rbyte};
      OP_LH:   load_val = {{16{rhalf[15]}}, rhalf};
      OP_LHU:  load_val = {16'h0, rhalf};
      default: load_val = data_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= 6'h0;
      vaddr_q    <= 32'h0;
      data_wr    <= 1'b0;
      data_be    <= 4'h0;
      data_addr  <= '0;
      data_wdata <= 32'h0;
      readdataM  <= 32'h0;
      badvaddr   <= 32'h0;
    end else begin
      state <= state_nxt;
      if (start) begin
        op_q       <= opM;
        vaddr_q    <= aluoutM;
        data_wr    <= is_store;
        data_be    <= be_nxt;
        data_addr  <= ADDR_W'({aluoutM[31:2], 2'b00});
        data_wdata <= wdata_nxt;
      end
      if (done_ok && !data_wr) readdataM <= load_val;
      if (adel || ades)                  badvaddr <= aluoutM;
      else if (timeout && !done_ok)      badvaddr <= vaddr_q;
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store engine. It sits directly downstream of the pipelined datapath's M-stage registers.
- Consumes the M-stage address, store data and opcode. Drives a req/addr_ok/data_ok data bus and returns aligned, extended load data to the writeback register.
- Raises a stall while a bus transaction is outstanding. Flags misaligned accesses as address-error exceptions.

Parameters:
- ADDR_W, 32, bus address width
- TIMEOUT, 255, max cycles in WAIT before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- validM  in  1  M-stage slot holds a live instruction
- opM  in  6  M-stage opcode
- aluoutM  in  32  effective address
- writedataM  in  32  store source register value
- readdataM  out  32  aligned/extended load result, registered
- stall_mem  out  1  hold pipeline (F/D/E/M)
- adel  out  1  load address error, pulse
- ades  out  1  store address error, pulse
- badvaddr  out  32  faulting address, registered on adel/ades
- bus_err  out  1  timeout abort, pulse
- data_req  out  1  bus request
- data_wr  out  1  1 = store
- data_be  out  4  byte enables
- data_addr  out  ADDR_W  word address, {aluoutM[31:2],2'b00}
- data_wdata  out  32  replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write complete
- data_rdata  in  32  read data

Behaviour:
- Memory ops:
  - Loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
  - Stores: SB 0x28, SH 0x29, SW 0x2B.
  - memop = validM & opcode in this set. Any other opcode is ignored.
- Alignment:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - Byte ops are always aligned.
- Misaligned memop:
  - In IDLE, for one cycle: adel (loads) or ades (stores) =1 and badvaddr<=aluoutM.
  - No bus request, stall_mem=0.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: aligned memop -> REQ; stall_mem=1 combinationally.
  - REQ: data_req=1, with addr/be/wr/wdata held stable from registers captured on IDLE->REQ.
    - addr_ok&data_ok -> DONE.
    - addr_ok only -> WAIT.
    - Otherwise stay in REQ with data_req held.
  - WAIT: data_req=0; data_ok -> DONE.
  - DONE: stall_mem=0 for exactly one cycle so the pipeline advances; -> IDLE.
  - The op in M during DONE is never reissued.
- Latency: minimum 3 cycles IDLE->REQ->DONE, with stall_mem high for 2 cycles.
- readdataM:
  - Captured on the data_ok cycle for loads. Held until the next load completes.
  - Unchanged by stores and errors.
- Load extension, little-endian, byte k = data_rdata[8k+7:8k], k = addr[1:0]:
  - LB: sign-extend byte k; LBU: zero-extend byte k.
  - LH/LHU: half addr[1] sign-/zero-extended.
  - LW: passthrough.
- Store encoding:
  - SB: be=1<<addr[1:0], wdata={4{wd[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{wd[15:0]}}.
  - SW: be=4'hF, wdata=wd.
  - Loads: data_wr=0, be=4'hF.
- Bus handshake: data_data_ok is ignored in IDLE and DONE, so stray responses are dropped.
- Reset, including mid-transaction: state=IDLE and all outputs 0 (readdataM=0, badvaddr=0). Outstanding responses are dropped per the rule above.
- adel/ades/bus_err are single-cycle pulses and never coincide with data_req.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined:
  - Counter cleared on entry to REQ, incremented each cycle in REQ/WAIT.
  - On reaching TIMEOUT without data_ok: -> DONE, bus_err=1 for one cycle, readdataM unchanged, badvaddr<=address.
- Undefined: no counter; bus_err tied 0; REQ/WAIT wait indefinitely.

Test Plan:
- LW addr 0x100, addr_ok&data_ok same cycle, rdata 0x12345678 -> data_req 1 cycle; stall_mem 2 cycles; readdataM=0x12345678.
- LB addr 0x103, rdata 0x80FF0000 -> readdataM=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x202, writedataM 0xAAAABEEF -> data_wr=1, be=4'b1100, wdata=0xBEEFBEEF, data_addr=0x200.
- LW addr 0x101 -> adel pulse 1 cycle, badvaddr=0x101, data_req never 1, stall_mem=0.
- SW, addr_ok delayed 3 cycles then data_ok 2 cycles later -> data_req held 4 cycles with stable addr/wdata; stall_mem high through data_ok; rst asserted in WAIT on a repeat -> IDLE next cycle, outputs 0.
- With MEM_TIMEOUT_EN and TIMEOUT=8, LW with no data_ok -> bus_err pulse after 8 cycles, stall_mem released, readdataM unchanged.
